// File: rtl/led_anim_engine.sv
// led_anim_engine: shared step timer plus one pattern state machine driving WIDTH LEDs with six animations.
module led_anim_engine #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] rate,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap
);
  localparam int LW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
  logic [2:0]       amode;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       pwm_cnt;
  logic [WIDTH-1:0] pat, pat_s, pat_n, fill, out_d;
  logic [LW-1:0]    lvl, lvl_s, lvl_n, top;
  logic             dir, dir_s, dir_n, mode_chg, valid, wrap_s;
  // dir doubles as the bounce/fill/breathe direction and the blink phase
  always_comb begin
    mode_chg = mode != amode;
    valid = amode[2:1] != 2'b11;
    tick = rst & en & valid & ~mode_chg & (div_cnt == rate);
    top = (amode == 3'd3) ? LW'(WIDTH) : LW'(15);
    pat_s = pat;
    dir_s = dir;
    lvl_s = lvl;
    wrap_s = 1'b0;
    case (amode)
      3'd0: begin
        pat_s = {pat[WIDTH-2:0], pat[WIDTH-1]};
        wrap_s = pat[WIDTH-1];
      end
      3'd1: begin
        pat_s = {pat[0], pat[WIDTH-1:1]};
        wrap_s = pat[0];
      end
      3'd2: begin
        pat_s = dir ? pat >> 1 : pat << 1;
        dir_s = dir ? ~pat[1] : pat[WIDTH-2];
        wrap_s = dir & pat[1];
      end
      3'd3, 3'd5: begin
        lvl_s = dir ? lvl - LW'(1) : lvl + LW'(1);
        dir_s = dir ? (lvl != LW'(1)) : (lvl == top - LW'(1));
        wrap_s = dir & (lvl == LW'(1));
      end
      3'd4: begin
        dir_s = ~dir;
        wrap_s = dir;
      end
      default: ;
    endcase
    wrap = tick & wrap_s;
    pat_n = mode_chg ? ((mode == 3'd1) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1)) : tick ? pat_s : pat;
    dir_n = mode_chg ? 1'b0 : tick ? dir_s : dir;
    lvl_n = mode_chg ? '0 : tick ? lvl_s : lvl;
    fill = '0;
    for (int i = 0; i < WIDTH; i++) fill[i] = LW'(i) < lvl_n;
    out_d = !en ? '0 :
            (mode <= 3'd2) ? pat_n :
            (mode == 3'd3) ? fill :
            (mode == 3'd4) ? {WIDTH{~dir_n}} :
            (mode == 3'd5) ? {WIDTH{pwm_cnt < lvl_n[3:0]}} : '0;
  end
  // amode always takes mode: when they already match the load is a no-op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amode <= '0;
      div_cnt <= '0;
      pwm_cnt <= '0;
      pat <= WIDTH'(1);
      dir <= 1'b0;
      lvl <= '0;
      out <= '0;
    end else begin
      amode <= mode;
      pat <= pat_n;
      dir <= dir_n;
      lvl <= lvl_n;
      out <= out_d;
      div_cnt <= (mode_chg | tick) ? '0 : (en & valid) ? div_cnt + DIV_W'(1) : div_cnt;
      pwm_cnt <= pwm_cnt + 4'(en);
    end
  end
endmodule

// File: tb/tb_led_anim_engine.sv
// tb_led_anim_engine: directed vector table plus hand-written multi-cycle sequences for led_anim_engine.
module tb_led_anim_engine;
  logic        clk = 0, rst = 0, en = 0;
  logic [2:0]  mode = 0;
  logic [23:0] rate = 0;
  logic [7:0]  out;
  logic        tick, wrap;
  int          n_chk = 0, n_err = 0;
  typedef struct {
    logic        e;
    logic [2:0]  m;
    logic [23:0] r;
    logic [7:0]  o;
    logic        t;
    logic        w;
  } vec_t;
  vec_t tbl[$];

  led_anim_engine #(.WIDTH(8), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rate(rate),
    .out(out), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] eo, input logic et, input logic ew);
    cmp({nm, " out"}, out, eo);
    cmp({nm, " tick"}, {7'b0, tick}, {7'b0, et});
    cmp({nm, " wrap"}, {7'b0, wrap}, {7'b0, ew});
  endtask

  // one cycle: drive inputs, check mid-cycle, then step past the next edge
  task automatic cyc(input logic e, input logic [2:0] m, input logic [23:0] r,
                     input logic [7:0] eo, input logic et, input logic ew, input string nm);
    en = e;
    mode = m;
    rate = r;
    #1;
    chk(nm, eo, et, ew);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 0;
    #1;
    rst = 1;
  endtask

  // run-left at rate 3, row r counted from the first edge after reset
  task automatic m0_rows(input int a, input int b, input string nm);
    for (int r = a; r <= b; r++) begin
      int k;
      k = (r / 4) % 8;
      cyc(1, 0, 3, 8'h01 << k, (r % 4) == 3, ((r % 4) == 3) && (k == 7), $sformatf("%s%0d", nm, r));
    end
  endtask

  task automatic v(input logic e, input logic [2:0] m, input logic [23:0] r,
                   input logic [7:0] o, input logic t, input logic w);
    tbl.push_back('{e, m, r, o, t, w});
  endtask

  initial begin
    int on0, on8, on15;
    v(1, 2, 0, 8'h00, 0, 0);
    v(1, 2, 0, 8'h01, 1, 0); v(1, 2, 0, 8'h02, 1, 0); v(1, 2, 0, 8'h04, 1, 0); v(1, 2, 0, 8'h08, 1, 0);
    v(1, 2, 0, 8'h10, 1, 0); v(1, 2, 0, 8'h20, 1, 0); v(1, 2, 0, 8'h40, 1, 0); v(1, 2, 0, 8'h80, 1, 0);
    v(1, 2, 0, 8'h40, 1, 0); v(1, 2, 0, 8'h20, 1, 0); v(1, 2, 0, 8'h10, 1, 0); v(1, 2, 0, 8'h08, 1, 0);
    v(1, 2, 0, 8'h04, 1, 0); v(1, 2, 0, 8'h02, 1, 1); v(1, 2, 0, 8'h01, 1, 0);
    v(1, 3, 0, 8'h02, 0, 0);
    v(1, 3, 0, 8'h00, 1, 0); v(1, 3, 0, 8'h01, 1, 0); v(1, 3, 0, 8'h03, 1, 0); v(1, 3, 0, 8'h07, 1, 0);
    v(1, 3, 0, 8'h0F, 1, 0); v(1, 3, 0, 8'h1F, 1, 0); v(1, 3, 0, 8'h3F, 1, 0); v(1, 3, 0, 8'h7F, 1, 0);
    v(1, 3, 0, 8'hFF, 1, 0); v(1, 3, 0, 8'h7F, 1, 0); v(1, 3, 0, 8'h3F, 1, 0); v(1, 3, 0, 8'h1F, 1, 0);
    v(1, 3, 0, 8'h0F, 1, 0); v(1, 3, 0, 8'h07, 1, 0); v(1, 3, 0, 8'h03, 1, 0); v(1, 3, 0, 8'h01, 1, 1);
    v(1, 3, 0, 8'h00, 1, 0);
    v(1, 4, 2, 8'h01, 0, 0);
    v(1, 4, 2, 8'hFF, 0, 0); v(1, 4, 2, 8'hFF, 0, 0); v(1, 4, 2, 8'hFF, 1, 0);
    v(1, 4, 2, 8'h00, 0, 0); v(1, 4, 2, 8'h00, 0, 0); v(1, 4, 2, 8'h00, 1, 1); v(1, 4, 2, 8'hFF, 0, 0);
    v(1, 6, 0, 8'hFF, 0, 0); v(1, 6, 0, 8'h00, 0, 0); v(1, 6, 0, 8'h00, 0, 0);
    v(1, 1, 0, 8'h00, 0, 0);
    v(1, 1, 0, 8'h80, 1, 0); v(1, 1, 0, 8'h40, 1, 0); v(1, 1, 0, 8'h20, 1, 0); v(1, 1, 0, 8'h10, 1, 0);
    v(1, 1, 0, 8'h08, 1, 0); v(1, 1, 0, 8'h04, 1, 0); v(1, 1, 0, 8'h02, 1, 0); v(1, 1, 0, 8'h01, 1, 1);
    v(1, 1, 0, 8'h80, 1, 0);
    v(0, 0, 0, 8'h40, 0, 0); v(0, 0, 0, 8'h00, 0, 0);
    v(1, 0, 0, 8'h00, 1, 0); v(1, 0, 0, 8'h02, 1, 0);
    // reset held with en=1 and rate=0: tick must stay low
    rst = 0;
    en = 1;
    @(posedge clk);
    #1;
    chk("reset", 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk("reset held", 8'h00, 0, 0);
    rst = 1;
    cyc(1, 0, 3, 8'h00, 0, 0, "m0 row0");
    m0_rows(1, 36, "runleft");
    // vector table
    do_reset;
    foreach (tbl[i]) cyc(tbl[i].e, tbl[i].m, tbl[i].r, tbl[i].o, tbl[i].t, tbl[i].w, $sformatf("tbl%0d", i));
    // enable gap at out=08, then resume and a mode load that clears div_cnt
    do_reset;
    cyc(1, 0, 3, 8'h00, 0, 0, "gap row0");
    m0_rows(1, 12, "gap pre");
    cyc(0, 0, 3, 8'h08, 0, 0, "gap start");
    for (int i = 0; i < 9; i++) cyc(0, 0, 3, 8'h00, 0, 0, $sformatf("gap%0d", i));
    cyc(1, 0, 3, 8'h00, 0, 0, "resume0");
    cyc(1, 0, 3, 8'h08, 0, 0, "resume1");
    cyc(1, 0, 3, 8'h08, 1, 0, "resume2");
    cyc(1, 0, 3, 8'h10, 0, 0, "resume3");
    cyc(1, 0, 3, 8'h10, 0, 0, "resume4");
    cyc(1, 4, 3, 8'h10, 0, 0, "load blink");
    cyc(1, 4, 3, 8'hFF, 0, 0, "blink0");
    cyc(1, 4, 3, 8'hFF, 0, 0, "blink1");
    cyc(1, 4, 3, 8'hFF, 0, 0, "blink2");
    cyc(1, 4, 3, 8'hFF, 1, 0, "blink3");
    cyc(1, 4, 3, 8'h00, 0, 0, "blink4");
    // asynchronous reset mid-step
    do_reset;
    cyc(1, 0, 3, 8'h00, 0, 0, "ar row0");
    m0_rows(1, 6, "ar pre");
    #2;
    rst = 0;
    #1;
    chk("async rst", 8'h00, 0, 0);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    m0_rows(1, 8, "ar post");
    // breathe at rate 15: duty climbs one step per 16 cycles, wraps after 30 ticks
    do_reset;
    cyc(1, 5, 15, 8'h00, 0, 0, "brth row0");
    on0 = 0;
    on8 = 0;
    on15 = 0;
    for (int r = 1; r <= 496; r++) begin
      int t, d;
      t = (r - 1) / 16;
      d = (t % 30 <= 15) ? t % 30 : 30 - t % 30;
      if (out == 8'hFF) begin
        if (t == 0) on0++;
        if (t == 8) on8++;
        if (t == 15) on15++;
      end
      cyc(1, 5, 15, (((r - 1) % 16) < d) ? 8'hFF : 8'h00, (r % 16) == 0,
          ((r % 16) == 0) && ((r / 16) % 30 == 0), $sformatf("brth%0d", r));
    end
    cmp("brth duty0 on", 8'(on0), 8'd0);
    cmp("brth duty8 on", 8'(on8), 8'd8);
    cmp("brth duty15 on", 8'(on15), 8'd15);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/led_anim_engine.md
# led_anim_engine

Parametrised LED animation engine producing a WIDTH-bit LED pattern. It has a programmable step rate, six selectable animations, glitch-free mode switching and step/wrap strobes. It replaces the fixed 8-bit five-generator mux at the top of the LED path: one shared step timer and one pattern state machine instead of parallel free-running generators. It drives the LED pins directly.

## Interface

- WIDTH, 8, number of LED outputs; must be ≥ 2
- DIV_W, 24, width of the step-rate divider

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  run enable; low freezes the animation and blanks `out`
- mode  input  3  animation select (see Operation)
- rate  input  DIV_W  step period minus one, in clk cycles
- out  output  WIDTH  registered LED pattern
- tick  output  1  one-cycle pulse on each animation step
- wrap  output  1  one-cycle pulse on the step that completes a full pattern period

## Operation

- Step timer: `div_cnt` counts 0..`rate`. `tick`=1 while `en`=1, the mode is valid and `div_cnt`==`rate`. On tick, `div_cnt` returns to 0. `rate`=0 gives a tick every cycle.
- `rate` is compared live. If `rate` is lowered below the current `div_cnt`, the counter wraps through 2^DIV_W; no special handling.
- Active mode register `amode`. When `mode` differs from `amode`, the next edge does all of the following:
  - loads `amode`;
  - clears `div_cnt`;
  - reloads the pattern state to the new mode's initial value.
- No tick is issued on a mode-load edge.
- Pattern advances one step on each tick. Initial state and sequence per mode:
  - 0 run-left: one-hot, starts at bit 0, rotates toward the MSB, MSB→bit 0. Period WIDTH.
  - 1 run-right: one-hot, starts at the MSB, rotates toward bit 0, bit 0→MSB. Period WIDTH.
  - 2 bounce: one-hot, starts at bit 0 moving up. Reverses at the MSB and at bit 0 without repeating the end position. Period 2·WIDTH−2.
  - 3 fill: thermometer level L. Out = (1<<L)−1. L goes 0,1,…,WIDTH,WIDTH−1,…,1, then back to 0. Period 2·WIDTH.
  - 4 blink: all-ones then all-zeros. Period 2.
  - 5 breathe: 4-bit duty D goes 0,1,…,15,14,…,1, then back to 0. Period 30.
    - A 4-bit `pwm_cnt` free-runs while `en`=1.
    - Every bit of `out` = (`pwm_cnt` < D).
  - 6, 7 off: `out`=0. `tick` and `wrap` stay 0.
- `wrap` is asserted together with `tick` when that step returns the pattern to its initial state.
- `en`=0:
  - `div_cnt`, pattern state and `pwm_cnt` hold;
  - `out` goes to 0 on the next edge;
  - `tick` and `wrap` are 0.
- `en` rising resumes from the held state and held `div_cnt`. `out` shows the held pattern on the next edge.
- Mode change with `en`=0: `amode` is still loaded and the state reloaded. `out` stays 0.
- Reset values:
  - `out`=0, `tick`=0, `wrap`=0;
  - `div_cnt`=0, `pwm_cnt`=0;
  - `amode`=0, pattern state = mode-0 initial (bit 0).

## Timing

- `tick` and `wrap` are combinational from registered state and `en`, valid within the cycle.
- The pattern state updates on the edge ending a tick cycle. `out` is registered from the next-state value, so the new pattern appears the cycle after `tick`=1.
- From the edge that loads `amode`, `out` shows the new mode's initial pattern (if `en`=1). The first tick follows `rate` cycles later.
- Breathe: `out` follows `pwm_cnt` with one cycle of latency.
- After reset deasserts with `en`=1, `out`=…0001 from the first edge, and the first tick arrives at `div_cnt`==`rate`.
- Reset asserted mid-animation: all registers clear immediately, with no clock needed.

## Test plan

- WIDTH=8, `rate`=3, `mode`=0, `en`=1 → `tick` every 4 cycles. `out` steps 01,02,04,…,80, then 01. `wrap` pulses with the tick that returns to 01.
- `mode`=2, `rate`=0 → `out` sequence 01,02,…,80,40,…,02, then 01. Period 14 cycles; `wrap` every 14 ticks.
- `mode`=3, `rate`=0 → 00,01,03,…,FF,7F,…,01, then 00. Period 16. Switch to `mode`=4 mid-sequence → next cycle `out`=FF, `div_cnt`=0, and that edge has no `tick`.
- `mode`=5, `rate`=15, WIDTH=4 → at D=8, `out`=F for 8 of every 16 cycles. At D=0, `out`=0 always. D peaks at 15 after 15 ticks.
- `en` dropped for 10 cycles in mode 0 at `out`=08 → `out`=00 and no ticks during the gap. On re-enable, `out`=08 and stepping resumes with the same `div_cnt`.
- `rst` pulsed low asynchronously mid-step → `out`/`tick`/`wrap`=0 immediately. After release, `amode`=0 and `out`=01.
